// File: rtl/laji_intr_pkg.sv
// Shared types and helpers for the interrupt arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package laji_intr_pkg;

  // Arbiter handshake state: no request outstanding, or request offered to core
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_e;

  // Default handler layout: source 0 at 0x80, one 32-byte slot per source
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic int unsigned lsb_index(input logic [31:0] v);
    lsb_index = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lsb_index = i;
    end
  endfunction

endpackage

// File: rtl/intr_edge_sync.sv
// Two-flop synchroniser for one raw interrupt line plus a rising-edge pulse.
// Latency: rise asserts after the second edge that samples d high; one cycle wide.
// Backpressure: none; free-running in the core clock domain.
module intr_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  // Synchronise the asynchronous level, then keep a delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// Priority interrupt arbiter: edge-latched pending, mask, in-service tracking, req/ack to core.
// Latency: raw line stable before edge k -> pending at k+2 -> irq at k+3 earliest; all outputs registered.
// Backpressure: one request outstanding until irq_ack; en low freezes FSM/in-service/counter.
// Optional feature: define INTR_NESTING_EN to let a strictly higher-priority source preempt a handler.
module interrupt_arbiter
  import laji_intr_pkg::*;
#(
  parameter int          NumSrc    = 3,
  parameter logic [31:0] VecBase   = VEC_BASE_DEF,
  parameter logic [31:0] VecStride = VEC_STRIDE_DEF,
  localparam int         IdBit     = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NumSrc-1:0] int_raw,
  input  logic              mask_we,
  input  logic [NumSrc-1:0] mask_wdata,
  input  logic              irq_ack,
  input  logic              eret,
  output logic              irq,
  output logic [IdBit-1:0]  irq_id,
  output logic [31:0]       irq_vec,
  output logic [NumSrc-1:0] pending,
  output logic [NumSrc-1:0] in_service,
  output logic [31:0]       svc_cnt,
  output logic              eret_err
);

  localparam logic [NumSrc-1:0] ONE = NumSrc'(1);

  arb_state_e        state_q;
  logic              irq_q;
  logic [IdBit-1:0]  irq_id_q;
  logic [31:0]       irq_vec_q;
  logic [31:0]       svc_cnt_q;
  logic [NumSrc-1:0] pending_q, pending_d;
  logic [NumSrc-1:0] mask_q;
  logic [NumSrc-1:0] in_service_q, in_service_d;
  logic              eret_err_q, eret_err_d;

  logic [NumSrc-1:0] rise;
  logic [NumSrc-1:0] is_low;
  logic [NumSrc-1:0] prio_ok;
  logic [NumSrc-1:0] eligible;
  logic [31:0]       elig_ext;
  logic [IdBit-1:0]  win_id;
  logic [31:0]       win_vec;
  logic              ack_fire;
  logic [NumSrc-1:0] ack_vec;

  for (genvar g = 0; g < NumSrc; g++) begin : g_sync
    intr_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (int_raw[g]),
      .rise (rise[g])
    );
  end

  // Eligibility: pending, unmasked, and allowed by the active handler set
  always_comb begin
    is_low = in_service_q & (~in_service_q + ONE);
`ifdef INTR_NESTING_EN
    // Bits strictly below the most recently nested handler; all ones when idle
    prio_ok = is_low - ONE;
`else
    prio_ok = (in_service_q == '0) ? '1 : '0;
`endif
    eligible = pending_q & mask_q & prio_ok;
    elig_ext = '0;
    elig_ext[NumSrc-1:0] = eligible;
    win_id  = IdBit'(lsb_index(elig_ext));
    win_vec = VecBase + VecStride * 32'(win_id);
  end

  // Ack effects and in-service/error next state; eret acts on the old set before the ack bit lands
  always_comb begin
    ack_fire     = en && irq_ack && (state_q == REQ);
    ack_vec      = ack_fire ? (ONE << irq_id_q) : '0;
    pending_d    = (pending_q & ~ack_vec) | rise;
    in_service_d = in_service_q;
    eret_err_d   = eret_err_q;
    if (en && eret) begin
      if (in_service_q == '0) eret_err_d = 1'b1;
      else                    in_service_d = in_service_q & ~is_low;
    end
    in_service_d = in_service_d | ack_vec;
  end

  // Request FSM with registered irq/id/vector and service counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      irq_vec_q <= VecBase;
      svc_cnt_q <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            state_q   <= REQ;
            irq_q     <= 1'b1;
            irq_id_q  <= win_id;
            irq_vec_q <= win_vec;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            svc_cnt_q <= svc_cnt_q + 32'd1;
          end else if (!mask_q[irq_id_q]) begin
            // Request masked off while offered: withdraw, leave it pending
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  // Pending capture, mask register and in-service tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      mask_q       <= '1;
      in_service_q <= '0;
      eret_err_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      eret_err_q   <= eret_err_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign irq        = irq_q;
  assign irq_id     = irq_id_q;
  assign irq_vec    = irq_vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign svc_cnt    = svc_cnt_q;
  assign eret_err   = eret_err_q;

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Priority interrupt controller between the board interrupt buttons and the pipelined core. Synchronises and edge-detects the raw interrupt lines, latches pending requests, applies a software-written enable mask, and presents at most one request at a time to the core over a req/ack handshake. Tracks in-service sources until exception return, and counts serviced interrupts for the display mux. Runs in the core clock domain, gated by the core run-enable.

## Interface
- `NumSrc`, 3: number of interrupt sources. Index 0 has the highest priority.
- `VecBase`, 32'h0000_0080: handler address for source 0.
- `VecStride`, 32'h0000_0020: address distance between consecutive source handlers.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: core run-enable. When low, the arbiter FSM, in-service set and counter hold. Sync, edge capture and mask writes still operate.
- `int_raw` in NumSrc: asynchronous button levels.
- `mask_we` in 1: mask write strobe.
- `mask_wdata` in NumSrc: new mask value; 1 means enabled.
- `irq_ack` in 1: core accepts the current request; one-cycle pulse.
- `eret` in 1: core returns from a handler; one-cycle pulse.
- `irq` out 1: request to the core. Registered.
- `irq_id` out IdBit: index of the requesting source, where IdBit = max(1, $clog2(NumSrc)).
- `irq_vec` out 32: VecBase + irq_id*VecStride, truncated to 32 bits.
- `pending` out NumSrc: latched, not-yet-taken requests.
- `in_service` out NumSrc: sources whose handlers are active.
- `svc_cnt` out 32: total interrupts acknowledged. Wraps to 0.
- `eret_err` out 1: sticky flag, set when eret arrives with in_service == 0.

## Operation
- Per source: 2-FF synchroniser, then a delay FF. A rising edge is s2 & ~s3.
- An edge sets `pending[i]`. An edge on an already-pending source merges into the existing request (no count).
- Eligible set: pending & mask & priority filter.
  - Priority filter: source i qualifies only if i is lower than the lowest-indexed set bit of in_service. If in_service == 0, every source qualifies.
  - The winner is the lowest-indexed eligible source.
- FSM states: IDLE and REQ. `irq` = (state == REQ).
  - IDLE → REQ when en and eligible ≠ 0. The winner is latched into `irq_id`.
  - REQ → IDLE on en & irq_ack. Effects: pending[irq_id] cleared, in_service[irq_id] set, svc_cnt += 1.
  - REQ → IDLE (withdraw) when mask[irq_id] becomes 0. pending is untouched.
  - In REQ, `irq_id` and `irq_vec` are frozen. A newly arriving higher-priority source does not replace the current request.
- `irq_ack` while in IDLE is ignored.
- eret with en: clears the lowest-indexed set bit of in_service, i.e. the most recently nested handler. With in_service == 0, sets eret_err and nothing else changes.
- eret and irq_ack in the same cycle: eret is applied to the old in_service, then the ack bit is set.
- An edge arriving in the same cycle as the ack of the same source leaves pending = 1. This is a new request.
- mask_we and ack in the same cycle: the ack completes, and the new mask applies from the next cycle.
- Reset values: pending 0, in_service 0, mask all ones, sync FFs 0, state IDLE, irq 0, irq_id 0, irq_vec VecBase, svc_cnt 0, eret_err 0.

## Timing
- `int_raw` stable high before edge k: pending set at edge k+2 and visible after it. irq rises after edge k+3 at the earliest.
- Ack sampled at edge n: irq low after edge n. A next request can be raised at edge n+1.
- Mask write at edge n: effective for the eligibility evaluation made at edge n+1.
- Reset asserted during REQ or a service: everything returns to reset values on that edge. The core must also be reset.
- `en` low during REQ: irq stays high and an ack is ignored.

## Configuration
- `INTR_NESTING_EN` defined: the priority filter above applies, so a strictly higher-priority source preempts an active handler.
- `INTR_NESTING_EN` undefined: eligible = 0 whenever in_service ≠ 0. in_service holds at most one bit, and eret clears it.

## Structure
- Package `laji_intr_pkg`:
  - FSM state enum (IDLE, REQ).
  - Default VecBase and VecStride constants.
  - Function computing the lowest-set-bit index.
- Sub-module `intr_edge_sync`: one instance per source. Contains the 2-FF synchroniser plus rising-edge pulse; ports clk, rst, d, rise.

## Test plan
- int_raw[1] pulses high for 5 cycles → pending=3'b010, irq=1, irq_id=1, irq_vec=32'hA0. Ack → in_service=3'b010, svc_cnt=1, irq=0.
- int_raw[2] and int_raw[0] rise together → irq_id=0 first. After ack+eret, irq_id=2 with irq_vec=32'hC0.
- Nesting enabled: in_service=3'b100, then int0 edge → irq_id=0. Ack → in_service=3'b101. eret → 3'b100. Nesting disabled: no irq until eret.
- mask_wdata=3'b110 while pending[0]=1 in REQ → irq withdrawn and pending[0] remains 1. Restoring the mask re-raises irq_id=0.
- eret with in_service=0 → eret_err=1 and stays 1 until rst.
- en=0, then int1 edge → pending[1]=1 but irq stays 0. en=1 → irq the next cycle. rst during REQ → all outputs return to reset values on the next edge.
